// File: rtl/ppwm_pkg.sv
// rtl/ppwm_pkg.sv - serial program frame format shared by prog_tx and the instruction memory receiver
package ppwm_pkg;

    localparam logic FRAME_START_LEVEL = 1'b1;
    localparam logic FRAME_IDLE_LEVEL  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        GAP
    } tx_state_t;

endpackage

// File: rtl/prog_tx_tick.sv
// rtl/prog_tx_tick.sv - bit-time tick generator, one tick every BIT_CYCLES clocks
module prog_tx_tick #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] cnt;

    // Restart aligns the first bit time of a frame with the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == CW'(BIT_CYCLES - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(BIT_CYCLES - 1));

endmodule

// File: rtl/prog_tx.sv
// rtl/prog_tx.sv - serial program image transmitter; PROG_TX_BIT_DIV_EN enables the bit-time divider
module prog_tx
    import ppwm_pkg::*;
#(
    parameter int INSTR_WIDTH = 7,
    parameter int DEPTH       = 16,
    parameter int GAP_BITS    = 1,
    parameter int BIT_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   data_o
);

    localparam int BW = $clog2(INSTR_WIDTH + 1);
    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = $clog2(GAP_BITS + 1);

    if (GAP_BITS < 1) begin : g_bad_gap
        $error("prog_tx: GAP_BITS must be at least 1");
    end
    if (BIT_CYCLES < 2) begin : g_bad_div
        $error("prog_tx: BIT_CYCLES must be at least 2");
    end

    tx_state_t              state;
    logic [INSTR_WIDTH-1:0] shreg;
    logic [BW-1:0]          bit_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [FW-1:0]          frame_cnt;
    logic                   tick;
    logic                   handshake;

    assign handshake = instr_ready_o && instr_valid_i;

`ifdef PROG_TX_BIT_DIV_EN
    prog_tx_tick #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(handshake),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            frame_cnt     <= '0;
            instr_ready_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            data_o        <= FRAME_IDLE_LEVEL;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state         <= WAIT;
                        instr_ready_o <= 1'b1;
                        busy_o        <= 1'b1;
                    end
                end
                WAIT: begin
                    if (handshake) begin
                        shreg         <= instr_i;
                        state         <= START;
                        instr_ready_o <= 1'b0;
                        data_o        <= FRAME_START_LEVEL;
                    end
                end
                START: begin
                    if (tick) begin
                        data_o  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= BW'(1);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BW'(INSTR_WIDTH)) begin
                            data_o  <= FRAME_IDLE_LEVEL;
                            gap_cnt <= GW'(1);
                            state   <= GAP;
                        end else begin
                            data_o  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_BITS)) begin
                            if (frame_cnt == FW'(DEPTH - 1)) begin
                                frame_cnt <= '0;
                                done_o    <= 1'b1;
                                busy_o    <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                frame_cnt     <= frame_cnt + 1'b1;
                                instr_ready_o <= 1'b1;
                                state         <= WAIT;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    instr_ready_o <= 1'b0;
                    busy_o        <= 1'b0;
                    data_o        <= FRAME_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
